// File: rtl/lifo_stack_pkg.sv
// Shared definitions for the LIFO stack: operation encodings and default sizing.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package stack_pkg;

  localparam int WIDTH_DEFAULT      = 8;
  localparam int DEPTH_LOG2_DEFAULT = 3;

  // Operation decode is {push, pop}.
  typedef enum logic [1:0] {
    OP_NONE    = 2'b00,
    OP_POP     = 2'b01,
    OP_PUSH    = 2'b10,
    OP_REPLACE = 2'b11
  } op_e;

endpackage

// File: rtl/lifo_stack_if.sv
// Control/data bundle between the stack and its user (control unit / datapath).
// Latency: n/a (wiring only).
// Backpressure: none; overflow/underflow are reported through sticky flags.
interface lifo_stack_if
  import stack_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEFAULT,
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEFAULT
);

  logic                  push;
  logic                  pop;
  logic [WIDTH-1:0]      push_data;
  logic                  err_clr;
  logic [WIDTH-1:0]      top;
  logic [WIDTH-1:0]      next_top;
  logic [DEPTH_LOG2:0]   count;
  logic                  full;
  logic                  empty;
  logic                  overflow;
  logic                  underflow;

  // User side: issues operations, observes stack state.
  modport master (
    output push, pop, push_data, err_clr,
    input  top, next_top, count, full, empty, overflow, underflow
  );

  // Stack side.
  modport slave (
    input  push, pop, push_data, err_clr,
    output top, next_top, count, full, empty, overflow, underflow
  );

endinterface

// File: rtl/lifo_stack_mem.sv
// Storage array for the stack: one synchronous write port, two asynchronous read ports.
// Latency: write visible on reads after the writing edge; reads are combinational.
// Backpressure: none; contents are not reset and are only exposed through gated outputs.
module lifo_stack_mem
  import stack_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEFAULT,
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEFAULT
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic [DEPTH_LOG2-1:0] rd_addr_a,
  output logic [WIDTH-1:0]      rd_data_a,
  input  logic [DEPTH_LOG2-1:0] rd_addr_b,
  output logic [WIDTH-1:0]      rd_data_b
);

  logic [WIDTH-1:0] mem [2**DEPTH_LOG2];

  // Single write port; no reset because stale entries are never observable.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data_a = mem[rd_addr_a];
  assign rd_data_b = mem[rd_addr_b];

endmodule

// File: rtl/lifo_stack.sv
// LIFO stack with push/pop/replace, registered top/next_top/count views and sticky error flags.
// Latency: every output reflects an operation on the same edge that performs it; one op per cycle.
// Backpressure: none; push at full and pop at empty are dropped and latched into overflow/underflow.
module lifo_stack
  import stack_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEFAULT,
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEFAULT
) (
  input  logic         clk,
  input  logic         clr_n,
  lifo_stack_if.slave  bus
);

  localparam int                 CW    = DEPTH_LOG2 + 1;
  localparam int                 CAP_I = 1 << DEPTH_LOG2;
  localparam logic [CW-1:0]      CAP   = CW'(CAP_I);

  op_e                   op;
  logic [CW-1:0]         count_q;
  logic [CW-1:0]         new_count;
  logic [CW-1:0]         top_idx;
  logic [CW-1:0]         next_idx;
  logic                  wr_en;
  logic [DEPTH_LOG2-1:0] wr_addr;
  logic                  ovf_set;
  logic                  unf_set;
  logic [WIDTH-1:0]      rd_top;
  logic [WIDTH-1:0]      rd_next;
  logic [WIDTH-1:0]      top_nxt;
  logic [WIDTH-1:0]      next_top_nxt;

  logic [WIDTH-1:0]      top_q;
  logic [WIDTH-1:0]      next_top_q;
  logic                  full_q;
  logic                  empty_q;
  logic                  overflow_q;
  logic                  underflow_q;

  assign op = op_e'({bus.push, bus.pop});

  // Decode the operation into the next occupancy, the storage write and any error event.
  always_comb begin
    new_count = count_q;
    wr_en     = 1'b0;
    wr_addr   = '0;
    ovf_set   = 1'b0;
    unf_set   = 1'b0;
    unique case (op)
      OP_PUSH: begin
        if (count_q == CAP) begin
          ovf_set = 1'b1;
        end else begin
          wr_en     = 1'b1;
          wr_addr   = count_q[DEPTH_LOG2-1:0];
          new_count = count_q + CW'(1);
        end
      end
      OP_POP: begin
        if (count_q == '0) begin
          unf_set = 1'b1;
        end else begin
          new_count = count_q - CW'(1);
        end
      end
      OP_REPLACE: begin
        // Replace on an empty stack degrades to a plain push without an error.
        wr_en = 1'b1;
        if (count_q == '0) begin
          wr_addr   = '0;
          new_count = CW'(1);
        end else begin
          wr_addr = top_idx_of(count_q);
        end
      end
      default: begin
      end
    endcase
    // Reset dominates: a push asserted alongside reset must not touch storage.
    if (!clr_n) begin
      wr_en = 1'b0;
    end
  end

  function automatic logic [DEPTH_LOG2-1:0] top_idx_of(input logic [CW-1:0] c);
    logic [CW-1:0] t;
    t = c - CW'(1);
    return t[DEPTH_LOG2-1:0];
  endfunction

  assign top_idx  = new_count - CW'(1);
  assign next_idx = new_count - CW'(2);

  lifo_stack_mem #(
    .WIDTH      (WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_mem (
    .clk       (clk),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (bus.push_data),
    .rd_addr_a (top_idx[DEPTH_LOG2-1:0]),
    .rd_data_a (rd_top),
    .rd_addr_b (next_idx[DEPTH_LOG2-1:0]),
    .rd_data_b (rd_next)
  );

  // Post-operation views; the entry being written this cycle is forwarded so the
  // registered outputs already show it after the edge.
  always_comb begin
    top_nxt      = '0;
    next_top_nxt = '0;
    if (new_count != '0) begin
      top_nxt = (wr_en && wr_addr == top_idx[DEPTH_LOG2-1:0]) ? bus.push_data : rd_top;
    end
    if (new_count >= CW'(2)) begin
      next_top_nxt = (wr_en && wr_addr == next_idx[DEPTH_LOG2-1:0]) ? bus.push_data : rd_next;
    end
  end

  // Occupancy, derived status, output views and sticky flags (new error beats err_clr).
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      top_q       <= '0;
      next_top_q  <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= new_count;
      full_q      <= (new_count == CAP);
      empty_q     <= (new_count == '0);
      top_q       <= top_nxt;
      next_top_q  <= next_top_nxt;
      overflow_q  <= (overflow_q & ~bus.err_clr) | ovf_set;
      underflow_q <= (underflow_q & ~bus.err_clr) | unf_set;
    end
  end

  assign bus.count     = count_q;
  assign bus.full      = full_q;
  assign bus.empty     = empty_q;
  assign bus.top       = top_q;
  assign bus.next_top  = next_top_q;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;

endmodule
